// File: rtl/mmio_data_mem.sv
`default_nettype none
// =============================================================================
// mmio_data_mem : data RAM plus LED, timer and 8N1 UART-TX peripherals
// Revision      : 1.0
// =============================================================================
module mmio_data_mem #(
   parameter int RAM_WORDS    = 256,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_write,
   output logic [31:0] rdata,
   output logic [7:0]  led,
   output logic        timer_irq,
   output logic        uart_tx
);
   localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] C_BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   localparam logic [29:0] C_LED    = 30'h400;
   localparam logic [29:0] C_TCOUNT = 30'h401;
   localparam logic [29:0] C_TCMP   = 30'h402;
   localparam logic [29:0] C_TSTAT  = 30'h403;
   localparam logic [29:0] C_UTXD   = 30'h404;
   localparam logic [29:0] C_USTAT  = 30'h405;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [31:0]   r_mem [RAM_WORDS];
   logic [7:0]    r_led;
   logic [31:0]   r_tcount;
   logic [31:0]   r_tcmp;
   logic          r_flag;
   logic [1:0]    r_state,  w_state_nxt;
   logic [BW-1:0] r_baud,   w_baud_nxt;
   logic [2:0]    r_bit,    w_bit_nxt;
   logic [7:0]    r_txbyte, w_txbyte_nxt;

   logic [29:0]   w_word;
   logic [AW-1:0] w_ram_idx;
   logic          w_ram_sel;
   logic          w_wr_led, w_wr_tcount, w_wr_tcmp, w_wr_tstat, w_wr_utxd;
   logic          w_accept;
   logic          w_busy;
   logic          w_unused_addr;

   // Byte-lane bits and RAM index bits beyond the configured depth are don't-care.
   assign w_unused_addr = ^{addr[1:0], addr[9:2]};

   assign w_word      = addr[31:2];
   assign w_ram_sel   = (addr[31:10] == 22'd0);
   assign w_ram_idx   = addr[AW+1:2];
   assign w_wr_led    = mem_write && (w_word == C_LED);
   assign w_wr_tcount = mem_write && (w_word == C_TCOUNT);
   assign w_wr_tcmp   = mem_write && (w_word == C_TCMP);
   assign w_wr_tstat  = mem_write && (w_word == C_TSTAT);
   assign w_wr_utxd   = mem_write && (w_word == C_UTXD);
   assign w_accept    = w_wr_utxd && (r_state == S_IDLE);

   assign led       = r_led;
   assign timer_irq = r_flag;

   always_ff @(posedge clk) begin
      if (reset && mem_write && w_ram_sel) begin
         r_mem[w_ram_idx] <= wdata;
      end
   end

   // Compare uses the pre-edge count, so a match sets the flag one cycle later;
   // set takes priority over a simultaneous write-1-to-clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_led    <= 8'd0;
         r_tcount <= 32'd0;
         r_tcmp   <= 32'hFFFF_FFFF;
         r_flag   <= 1'b0;
      end else begin
         if (w_wr_led) r_led <= wdata[7:0];
         if (w_wr_tcount) r_tcount <= wdata;
         else             r_tcount <= r_tcount + 32'd1;
         if (w_wr_tcmp) r_tcmp <= wdata;
         if (r_tcount == r_tcmp)           r_flag <= 1'b1;
         else if (w_wr_tstat && wdata[0]) r_flag <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_bit    <= 3'd0;
         r_txbyte <= 8'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_baud   <= w_baud_nxt;
         r_bit    <= w_bit_nxt;
         r_txbyte <= w_txbyte_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_baud_nxt   = r_baud;
      w_bit_nxt    = r_bit;
      w_txbyte_nxt = r_txbyte;
      case (r_state)
         S_IDLE: begin
            w_baud_nxt = '0;
            w_bit_nxt  = 3'd0;
            if (w_accept) begin
               w_state_nxt  = S_START;
               w_txbyte_nxt = wdata[7:0];
            end
         end
         S_START: begin
            if (r_baud == C_BAUD_LAST) begin
               w_baud_nxt  = '0;
               w_bit_nxt   = 3'd0;
               w_state_nxt = S_DATA;
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         S_DATA: begin
            if (r_baud == C_BAUD_LAST) begin
               w_baud_nxt = '0;
               if (r_bit == 3'd7) begin
                  w_bit_nxt   = 3'd0;
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         S_STOP: begin
            if (r_baud == C_BAUD_LAST) begin
               w_baud_nxt  = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_baud_nxt  = '0;
            w_bit_nxt   = 3'd0;
         end
      endcase
   end

   always_comb begin
      w_busy  = (r_state != S_IDLE);
      uart_tx = 1'b1;
      case (r_state)
         S_START: uart_tx = 1'b0;
         S_DATA:  uart_tx = r_txbyte[r_bit];
         default: uart_tx = 1'b1;
      endcase
   end

   always_comb begin
      rdata = 32'd0;
      if (w_ram_sel) begin
         rdata = r_mem[w_ram_idx];
      end else begin
         case (w_word)
            C_LED:    rdata = {24'd0, r_led};
            C_TCOUNT: rdata = r_tcount;
            C_TCMP:   rdata = r_tcmp;
            C_TSTAT:  rdata = {31'd0, r_flag};
            C_USTAT:  rdata = {31'd0, w_busy};
            default:  rdata = 32'd0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mmio_data_mem.sv
`default_nettype none
// =============================================================================
// tb_mmio_data_mem : scoreboard bench for mmio_data_mem (CLKS_PER_BIT = 4)
// Revision         : 1.0
// =============================================================================
module tb_mmio_data_mem;
    localparam int CPB       = 4;
    localparam int SIG_RDATA = 0;
    localparam int SIG_LED   = 1;
    localparam int SIG_IRQ   = 2;
    localparam int SIG_TX    = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic        timer_irq;
    logic        uart_tx;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Expectations tagged with the cycle in which they must hold.
    int          q_cyc[$];
    int          q_sig[$];
    logic [31:0] q_exp[$];
    string       q_name[$];

    mmio_data_mem #(.RAM_WORDS(256), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .mem_write (mem_write),
        .rdata     (rdata),
        .led       (led),
        .timer_irq (timer_irq),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic [31:0] act;
        for (int i = q_cyc.size() - 1; i >= 0; i--) begin
            if (q_cyc[i] <= cyc) begin
                case (q_sig[i])
                    SIG_RDATA: act = rdata;
                    SIG_LED:   act = {24'd0, led};
                    SIG_IRQ:   act = {31'd0, timer_irq};
                    default:   act = {31'd0, uart_tx};
                endcase
                n_cmp++;
                if (q_cyc[i] < cyc || act !== q_exp[i]) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d: got %h expected %h", q_name[i], cyc, act, q_exp[i]);
                end
                q_cyc.delete(i);
                q_sig.delete(i);
                q_exp.delete(i);
                q_name.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_at(input int dly, input int sig, input logic [31:0] e, input string nm);
        q_cyc.push_back(cyc + dly);
        q_sig.push_back(sig);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        wdata     = d;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic load_chk(input logic [31:0] a, input logic [31:0] e, input string nm);
        addr      = a;
        mem_write = 1'b0;
        expect_at(0, SIG_RDATA, e, nm);
        tick();
    endtask

    // Frame index 0 is the first cycle after the accepting store edge.
    task automatic frame_exp(input logic [7:0] d, input int skip_a, input int skip_b, input string nm);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            expect_at(i, SIG_TX, {31'd0, fr[i / CPB]}, nm);
            if (i != skip_a && i != skip_b) expect_at(i, SIG_RDATA, 32'd1, {nm, "_busy"});
        end
    endtask

    initial begin
        reset     = 1'b0;
        addr      = 32'h2000;
        wdata     = 32'd0;
        mem_write = 1'b0;
        tick_n(2);

        // reset state
        expect_at(0, SIG_LED, 32'd0, "rst_led");
        expect_at(0, SIG_IRQ, 32'd0, "rst_irq");
        expect_at(0, SIG_TX,  32'd1, "rst_tx");
        load_chk(32'h1008, 32'hFFFF_FFFF, "rst_tcmp");
        load_chk(32'h1004, 32'd0, "rst_tcount");
        load_chk(32'h1014, 32'd0, "rst_busy");
        load_chk(32'h100C, 32'd0, "rst_tstat");
        reset = 1'b1;
        tick();

        // RAM
        store(32'h0000_0010, 32'hDEAD_BEEF);
        store(32'h0000_03FC, 32'h1234_5678);
        addr = 32'h0000_0010;
        #1;
        n_cmp++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL direct_ram_10: got %h", rdata);
        end
        load_chk(32'h0000_0010, 32'hDEAD_BEEF, "ram_10");
        load_chk(32'h0000_03FC, 32'h1234_5678, "ram_3fc");
        load_chk(32'h0000_0013, 32'hDEAD_BEEF, "ram_lowbits");

        // LED and unmapped space
        store(32'h1000, 32'hFFFF_FFA5);
        n_cmp++;
        if (led !== 8'hA5) begin
            n_bad++;
            $display("FAIL direct_led: got %h", led);
        end
        expect_at(0, SIG_LED, 32'hA5, "led_pin");
        load_chk(32'h1000, 32'h0000_00A5, "led_rd");
        load_chk(32'h2000, 32'd0, "unmapped_rd");
        load_chk(32'h1010, 32'd0, "utxd_rd");
        store(32'h2000, 32'hFFFF_FFFF);
        expect_at(0, SIG_LED, 32'hA5, "led_after_unmapped");
        expect_at(0, SIG_TX,  32'd1,  "tx_after_unmapped");
        load_chk(32'h1000, 32'h0000_00A5, "led_rd_after_unmapped");
        load_chk(32'h0000_0010, 32'hDEAD_BEEF, "ram_after_unmapped");
        load_chk(32'h1008, 32'hFFFF_FFFF, "tcmp_after_unmapped");

        // timer compare: TCOUNT reads k in cycle T0+k
        store(32'h1008, 32'd20);
        store(32'h1004, 32'd0);
        load_chk(32'h1004, 32'd0, "tcount_load");
        load_chk(32'h1008, 32'd20, "tcmp_rd");
        expect_at(18, SIG_IRQ, 32'd0, "irq_before_match");
        expect_at(19, SIG_IRQ, 32'd1, "irq_rise");
        expect_at(24, SIG_IRQ, 32'd1, "irq_sticky");
        addr = 32'h2000;
        tick_n(18);
        load_chk(32'h1004, 32'd20, "tcount_20");
        load_chk(32'h100C, 32'd1, "tstat_set");
        tick_n(4);
        store(32'h100C, 32'd1);
        expect_at(0, SIG_IRQ, 32'd0, "irq_w1c");
        load_chk(32'h100C, 32'd0, "tstat_clr");

        // W1C in the match cycle: set wins
        store(32'h1004, 32'd18);
        expect_at(0, SIG_IRQ, 32'd0, "irq_pre_setwin");
        tick_n(2);
        store(32'h100C, 32'd1);
        expect_at(0, SIG_IRQ, 32'd1, "irq_set_wins");

        // wrap
        store(32'h1004, 32'hFFFF_FFFE);
        load_chk(32'h1004, 32'hFFFF_FFFE, "tcount_fffe");
        load_chk(32'h1004, 32'hFFFF_FFFF, "tcount_ffff");
        load_chk(32'h1004, 32'd0, "tcount_wrap");

        // UART 0x55 frame
        n_cmp++;
        if (uart_tx !== 1'b1) begin
            n_bad++;
            $display("FAIL direct_tx_idle: got %b", uart_tx);
        end
        load_chk(32'h1014, 32'd0, "busy_idle");
        expect_at(0, SIG_TX, 32'd1, "tx_idle");
        store(32'h1010, 32'h155);
        addr = 32'h1014;
        frame_exp(8'h55, -1, -1, "f55");
        tick_n(40);
        expect_at(0, SIG_TX, 32'd1, "f55_tx_end");
        load_chk(32'h1014, 32'd0, "f55_busy_end");

        // busy drop mid-frame and in last STOP cycle; first IDLE store accepted
        store(32'h1010, 32'h41);
        addr = 32'h1014;
        frame_exp(8'h41, 15, 39, "f41");
        tick_n(15);
        store(32'h1010, 32'h42);
        addr = 32'h1014;
        tick_n(23);
        store(32'h1010, 32'h7E);
        expect_at(0, SIG_TX, 32'd1, "tx_gap");
        store(32'h1010, 32'h33);
        addr = 32'h1014;
        frame_exp(8'h33, -1, -1, "f33");
        tick_n(40);
        expect_at(0, SIG_TX, 32'd1, "f33_tx_end");
        load_chk(32'h1014, 32'd0, "f33_busy_end");

        // reset mid-frame (during DATA)
        store(32'h1010, 32'h96);
        addr = 32'h1014;
        expect_at(0, SIG_TX, 32'd0, "f96_start");
        expect_at(0, SIG_RDATA, 32'd1, "f96_busy");
        expect_at(11, SIG_IRQ, 32'd1, "irq_before_rst");
        tick_n(12);
        reset = 1'b0;
        tick();
        n_cmp++;
        if (uart_tx !== 1'b1) begin
            n_bad++;
            $display("FAIL direct_rst_mid_tx: got %b", uart_tx);
        end
        expect_at(0, SIG_TX,  32'd1, "rst_mid_tx");
        expect_at(0, SIG_LED, 32'd0, "rst_mid_led");
        expect_at(0, SIG_IRQ, 32'd0, "rst_mid_irq");
        load_chk(32'h1014, 32'd0, "rst_mid_busy");
        load_chk(32'h1004, 32'd0, "rst_mid_tcount");
        reset = 1'b1;
        tick();
        load_chk(32'h1014, 32'd0, "post_rst_busy");
        store(32'h1010, 32'hC3);
        addr = 32'h1014;
        frame_exp(8'hC3, -1, -1, "fC3");
        tick_n(40);
        expect_at(0, SIG_TX, 32'd1, "fC3_tx_end");
        load_chk(32'h1014, 32'd0, "fC3_busy_end");

        tick_n(2);
        for (int i = 0; i < q_cyc.size(); i++) begin
            n_bad++;
            $display("FAIL %s: expectation for cyc %0d never compared (now %0d)", q_name[i], q_cyc[i], cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_data_mem.md
# mmio_data_mem

Data-side memory and memory-mapped I/O block that sits directly downstream of the single-cycle RISC-V core.
- Consumes the core's data address (`alu_result`), store data (`write_data`) and `mem_write`.
- Returns load data on `read_data` in the same cycle.
- Decodes a word-addressed data RAM plus a small peripheral space: LED register, free-running timer with compare flag, and an 8N1 UART transmitter.

## Interface
Parameters:
- `RAM_WORDS`, default 256: data RAM depth in 32-bit words (power of two, ≤ 256).
- `CLKS_PER_BIT`, default 434: UART bit period in clk cycles (≥ 2).

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `addr`  in  32  byte address from core ALU result.
- `wdata`  in  32  store data.
- `mem_write`  in  1  store strobe, sampled on the clock edge.
- `rdata`  out  32  load data, combinational from `addr`.
- `led`  out  8  LED register.
- `timer_irq`  out  1  timer match flag.
- `uart_tx`  out  1  serial output, idles high.

## Operation
- Word access only; `addr[1:0]` is ignored. Stores are full 32-bit.
- Address map:
  - 0x0000_0000–0x0000_03FF: RAM, word index `addr[9:2]` masked to RAM_WORDS.
  - 0x1000 LED: read/write, bits [7:0]; upper bits read 0.
  - 0x1004 TCOUNT: read/write.
  - 0x1008 TCMP: read/write.
  - 0x100C TSTAT: bit0 = match flag; write 1 to clear.
  - 0x1010 UTXD: write-only; reads 0.
  - 0x1014 USTAT: bit0 = busy; read-only.
- All other addresses read 0x0000_0000. Stores to them are ignored.
- RAM: stores write on the edge. Loads read combinationally. RAM contents are not cleared by reset.
- Timer:
  - TCOUNT increments by 1 every cycle and wraps 0xFFFF_FFFF→0.
  - A store to TCOUNT loads `wdata`; there is no increment that cycle.
  - The flag sets on the edge of any cycle where TCOUNT == TCMP and is sticky.
  - A W1C and a set in the same cycle: set wins.
  - `timer_irq` = flag.
- UART state machine, states IDLE, START, DATA, STOP:
  - IDLE: `uart_tx`=1. A store to UTXD latches `wdata[7:0]` and moves to START.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Uses a bit counter 0..7.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles, then IDLE.
  - busy = (state != IDLE). A UTXD store while busy is dropped and has no side effects.

## Timing
- `rdata` is valid combinationally the same cycle as `addr`. There are no wait states, which the single-cycle core requires.
- Store effects are visible to loads in the cycle after the store edge.
- Reset values on the edge with `reset`=0:
  - `led` = 0; TCOUNT = 0; TCMP = 0xFFFF_FFFF; flag = 0, so `timer_irq` = 0.
  - UART state = IDLE and `uart_tx` = 1; bit counter and baud counter = 0.
- Reset asserted mid-transmission aborts the frame: `uart_tx` is 1 after that edge.
- UART frame length is exactly 10×CLKS_PER_BIT cycles:
  - `uart_tx` falls on the edge after the accepting store.
  - USTAT.busy reads 1 starting from that same post-store cycle.
  - busy drops after the final stop-bit cycle.
- A UTXD store in the last STOP cycle is dropped. A store in the first IDLE cycle is accepted.
- Timer: after a store of TCMP=N, the flag reads 1 in the cycle after TCOUNT reads N.

## Test plan
- RAM: store 0xDEADBEEF to 0x0000_0010 and 0x1234_5678 to 0x0000_03FC, then load both. Required: exact values read back. A load of 0x0000_0014 (never written after reset) is not checked.
- LED and unmapped space:
  - Store 0xFFFF_FFA5 to 0x1000 → `led`=0xA5; load 0x1000 = 0x0000_00A5.
  - Load 0x2000 = 0.
  - Store to 0x2000 changes no state.
- Timer:
  - Release reset, store TCMP=20. Required: `timer_irq` rises the cycle after TCOUNT=20 and stays high.
  - Store 1 to TSTAT → `timer_irq`=0 next cycle.
  - Store TCOUNT=0xFFFF_FFFE → TCOUNT wraps to 0 two cycles later.
- UART frame with CLKS_PER_BIT=4: store 0x155 to UTXD. Required:
  - `uart_tx` sequence 0, then 1,0,1,0,1,0,1,0 (0x55 LSB first), then 1.
  - Each level held 4 cycles, 40 cycles total.
  - USTAT.busy = 1 throughout the frame, then 0.
- Busy drop: store 0x41, then store 0x42 mid-frame. Required: only the 0x41 frame appears and the frame timing is undisturbed.
- Reset mid-frame: assert `reset`=0 during DATA. Required:
  - `uart_tx`=1, busy=0, `led`=0, TCOUNT=0, `timer_irq`=0 after the edge.
  - A new UTXD store then transmits a full, correct frame.
